// File: rtl/UART_pkg.sv
`default_nettype none
// ============================================================================
// Package : UART_pkg
// Brief   : Shared UART types and constants for the receiver and its controller.
// Rev     : 1.0  initial release
// ============================================================================
package UART_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rcvr_state_e;

   typedef enum logic [2:0] {
      CT_IDLE     = 3'd0,
      CT_PUSH     = 3'd1,
      CT_ERR      = 3'd2,
      CT_ERR_WAIT = 3'd3,
      CT_DROP     = 3'd4,
      CT_CLR_WAIT = 3'd5
   } rx_ctrl_e;

   // Cycles spent waiting for the payload of a bad frame before giving up.
   localparam logic [2:0] ERR_WAIT_MAX = 3'd7;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_rx_ctrl_if
// Brief     : Receiver flag handshake, byte stream and status of uart_rx_ctrl.
// Rev       : 1.0  initial release
// ============================================================================
interface uart_rx_ctrl_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int ERR_CNT_WIDTH = 8
);
   localparam int c_FILL_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_WIDTH-1:0]    rcvr_data_i;
   logic                     rcvr_rdy_i;
   logic                     rcvr_err_i;
   logic                     rdy_clr_o;
   logic                     err_clr_o;
   logic [DATA_WIDTH-1:0]    m_data_o;
   logic                     m_valid_o;
   logic                     m_ready_i;
   logic [c_FILL_W-1:0]      fill_o;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_o;
   logic                     ovf_o;
   logic                     cnt_clr_i;

   modport slave (
      input  rcvr_data_i, rcvr_rdy_i, rcvr_err_i, m_ready_i, cnt_clr_i,
      output rdy_clr_o, err_clr_o, m_data_o, m_valid_o, fill_o, err_cnt_o, ovf_o
   );

   modport master (
      output rcvr_data_i, rcvr_rdy_i, rcvr_err_i, m_ready_i, cnt_clr_i,
      input  rdy_clr_o, err_clr_o, m_data_o, m_valid_o, fill_o, err_cnt_o, ovf_o
   );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : First-word-fall-through FIFO; a push into a full FIFO is accepted
//          when a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic                               clk_i,
   input  wire logic                               rst_i,
   input  wire logic                               push,
   input  wire logic                               pop,
   input  wire logic [DATA_WIDTH-1:0]              wdata,
   output logic      [DATA_WIDTH-1:0]              rdata,
   output logic                                    full,
   output logic                                    empty,
   output logic      [$clog2(FIFO_DEPTH):0]        count
);
   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;
   logic                  w_pop;
   logic                  w_push;

   assign empty  = (r_count == '0);
   assign full   = (r_count == c_DEPTH);
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);
   assign count  = r_count;
   assign rdata  = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_ctrl
// Brief  : Services the UART receiver flags, drops bytes of errored frames and
//          buffers good bytes into a valid/ready stream with error statistics.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_ctrl
   import UART_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  wire logic      clk_i,
   input  wire logic      rst_i,
   uart_rx_ctrl_if.slave  bus
);
   localparam int c_FILL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ERR_CNT_WIDTH-1:0] c_ERR_ONE = ERR_CNT_WIDTH'(1);

   rx_ctrl_e                 r_state;
   logic [2:0]               r_wait_cnt;
   logic                     r_rdy_clr;
   logic                     r_err_clr;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
   logic                     r_ovf;

   logic                     w_full;
   logic                     w_empty;
   logic                     w_pop;
   logic                     w_push;
   logic [DATA_WIDTH-1:0]    w_rdata;
   logic [c_FILL_W-1:0]      w_count;

   assign w_pop  = !w_empty && bus.m_ready_i;
   assign w_push = (r_state == CT_PUSH) && (!w_full || w_pop);

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (bus.rcvr_data_i),
      .rdata (w_rdata),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Clear pulses are set on entry to CT_PUSH/CT_DROP/CT_ERR so they track
   // the current state exactly while still coming from flops.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= CT_IDLE;
         r_wait_cnt <= '0;
         r_rdy_clr  <= 1'b0;
         r_err_clr  <= 1'b0;
      end else begin
         r_rdy_clr <= 1'b0;
         r_err_clr <= 1'b0;
         case (r_state)
            CT_IDLE: begin
               if (bus.rcvr_err_i) begin
                  r_state   <= CT_ERR;
                  r_err_clr <= 1'b1;
               end else if (bus.rcvr_rdy_i) begin
                  r_state   <= CT_PUSH;
                  r_rdy_clr <= 1'b1;
               end
            end
            CT_PUSH: begin
               r_state <= CT_CLR_WAIT;
            end
            CT_ERR: begin
               r_wait_cnt <= '0;
               r_state    <= CT_ERR_WAIT;
            end
            CT_ERR_WAIT: begin
               if (bus.rcvr_rdy_i) begin
                  r_state   <= CT_DROP;
                  r_rdy_clr <= 1'b1;
               end else if (r_wait_cnt == ERR_WAIT_MAX) begin
                  r_state <= CT_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 3'd1;
               end
            end
            CT_DROP: begin
               r_state <= CT_CLR_WAIT;
            end
            CT_CLR_WAIT: begin
               if (!bus.rcvr_rdy_i) begin
                  r_state <= CT_IDLE;
               end
            end
            default: begin
               r_state <= CT_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_err_cnt <= '0;
         r_ovf     <= 1'b0;
      end else if (bus.cnt_clr_i) begin
         r_err_cnt <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if ((r_state == CT_ERR) && (r_err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
            r_err_cnt <= r_err_cnt + c_ERR_ONE;
         end
         if ((r_state == CT_PUSH) && w_full && !w_pop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign bus.rdy_clr_o = r_rdy_clr;
   assign bus.err_clr_o = r_err_clr;
   assign bus.m_data_o  = w_rdata;
   assign bus.m_valid_o = !w_empty;
   assign bus.fill_o    = w_count;
   assign bus.err_cnt_o = r_err_cnt;
   assign bus.ovf_o     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_ctrl
// Brief  : Scoreboard bench for uart_rx_ctrl with a sticky-flag receiver model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_ctrl;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int EW    = 8;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   uart_rx_ctrl_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(EW)) bus ();

   uart_rx_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(EW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  exp_q [$];
   bit          exp_ovf = 1'b0;
   int          exp_err = 0;
   int          exp_rdy_pulses = 0;
   int          exp_err_pulses = 0;
   int          mon_rdy_pulses = 0;
   int          mon_err_pulses = 0;
   bit          ann_push = 1'b0;
   bit          ann_err  = 1'b0;
   logic [7:0]  ann_data = 8'h00;
   bit          prev_rdy_clr = 1'b0;
   bit          prev_err_clr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle step; the receiver drops a flag one edge after its clear pulse.
   task automatic tick();
      @(posedge clk_i);
      #3;
      if (prev_rdy_clr) bus.rcvr_rdy_i = 1'b0;
      if (prev_err_clr) bus.rcvr_err_i = 1'b0;
      prev_rdy_clr  = bus.rdy_clr_o;
      prev_err_clr  = bus.err_clr_o;
      ann_push      = 1'b0;
      ann_err       = 1'b0;
      bus.cnt_clr_i = 1'b0;
   endtask

   task automatic wait_idle(input int n);
      int cnt   = 0;
      int guard = 0;
      while (cnt < n) begin
         tick();
         guard++;
         if (!bus.rcvr_rdy_i && !bus.rcvr_err_i) cnt++;
         else cnt = 0;
         if (guard > 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: actual flags still set required cleared");
            break;
         end
      end
   endtask

   task automatic good_frame(input logic [7:0] d, input bit ready_in_push);
      bus.rcvr_rdy_i  = 1'b1;
      bus.rcvr_data_i = d;
      tick();
      ann_push = 1'b1;
      ann_data = d;
      exp_rdy_pulses++;
      if (ready_in_push) begin
         bus.m_ready_i = 1'b1;
         tick();
         bus.m_ready_i = 1'b0;
         wait_idle(1);
      end else begin
         wait_idle(2);
      end
   endtask

   // Bad frame; payload rdy arrives j cycles after the error flag, or a fresh
   // good byte arrives right when the wait window has expired.
   task automatic err_frame(input int j, input bit with_rdy, input bit tail_push,
                            input bit clr, input logic [7:0] d);
      bus.rcvr_err_i = 1'b1;
      exp_err_pulses++;
      if (with_rdy) exp_rdy_pulses++;
      if (with_rdy && j == 0) begin
         bus.rcvr_rdy_i  = 1'b1;
         bus.rcvr_data_i = d;
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) begin
            ann_err = 1'b1;
            if (clr) bus.cnt_clr_i = 1'b1;
         end
         if (with_rdy && k == j) begin
            bus.rcvr_rdy_i  = 1'b1;
            bus.rcvr_data_i = d;
         end
      end
      if (tail_push) begin
         bus.rcvr_rdy_i  = 1'b1;
         bus.rcvr_data_i = d;
         tick();
         ann_push = 1'b1;
         ann_data = d;
         exp_rdy_pulses++;
      end
      wait_idle(2);
   endtask

   task automatic pulse_clr();
      bus.cnt_clr_i = 1'b1;
      tick();
   endtask

   task automatic drain();
      int guard = 0;
      bus.m_ready_i = 1'b1;
      forever begin
         tick();
         guard++;
         if (!bus.m_valid_o) break;
         if (guard > 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: actual m_valid stuck high required empty");
            break;
         end
      end
      bus.m_ready_i = 1'b0;
   endtask

   // Monitor: compares DUT state against the queue model, then applies this
   // cycle's pop, push and counter events to the model.
   initial begin : p_monitor
      int sz;
      bit popped;
      bit last_rdy = 1'b0;
      bit last_err = 1'b0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            last_rdy = 1'b0;
            last_err = 1'b0;
         end else begin
            sz = exp_q.size();
            chk("fill", 32'(bus.fill_o), 32'(sz));
            chk("m_valid", 32'(bus.m_valid_o), 32'(sz != 0));
            if (sz != 0) chk("m_data", 32'(bus.m_data_o), 32'(exp_q[0]));
            chk("ovf", 32'(bus.ovf_o), 32'(exp_ovf));
            chk("err_cnt", 32'(bus.err_cnt_o), 32'(exp_err));
            if (bus.rdy_clr_o) begin
               mon_rdy_pulses++;
               chk("rdy_clr_width", 32'(last_rdy), 32'd0);
            end
            if (bus.err_clr_o) begin
               mon_err_pulses++;
               chk("err_clr_width", 32'(last_err), 32'd0);
            end
            last_rdy = bus.rdy_clr_o;
            last_err = bus.err_clr_o;
            popped = bus.m_ready_i && (sz != 0);
            if (popped) void'(exp_q.pop_front());
            if (ann_push) begin
               if (sz < DEPTH || popped) exp_q.push_back(ann_data);
               else if (!bus.cnt_clr_i) exp_ovf = 1'b1;
            end
            if (ann_err && !bus.cnt_clr_i && exp_err != 255) exp_err++;
            if (bus.cnt_clr_i) begin
               exp_err = 0;
               exp_ovf = 1'b0;
            end
         end
      end
   end

   initial begin : p_stim
      bus.rcvr_data_i = '0;
      bus.rcvr_rdy_i  = 1'b0;
      bus.rcvr_err_i  = 1'b0;
      bus.m_ready_i   = 1'b0;
      bus.cnt_clr_i   = 1'b0;
      #1 rst_i = 1'b1;
      #1;
      chk("rst_fill", 32'(bus.fill_o), 32'd0);
      chk("rst_err_cnt", 32'(bus.err_cnt_o), 32'd0);
      chk("rst_ovf", 32'(bus.ovf_o), 32'd0);
      chk("rst_rdy_clr", 32'(bus.rdy_clr_o), 32'd0);
      chk("rst_err_clr", 32'(bus.err_clr_o), 32'd0);
      chk("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
      chk("rst_m_data", 32'(bus.m_data_o), 32'd0);
      tick();
      tick();
      rst_i = 1'b0;
      wait_idle(2);

      good_frame(8'hA5, 1'b0);
      chk("good_fill", 32'(bus.fill_o), 32'd1);
      chk("good_data", 32'(bus.m_data_o), 32'hA5);
      drain();

      err_frame(2, 1'b1, 1'b0, 1'b0, 8'h3C);
      chk("errframe_cnt", 32'(bus.err_cnt_o), 32'd1);
      chk("errframe_fill", 32'(bus.fill_o), 32'd0);

      err_frame(0, 1'b0, 1'b1, 1'b0, 8'h96);
      chk("timeout_push_fill", 32'(bus.fill_o), 32'd1);
      err_frame(9, 1'b1, 1'b0, 1'b0, 8'h69);
      drain();

      pulse_clr();
      for (int i = 1; i <= 5; i++) good_frame(8'(i), 1'b0);
      chk("ovf_fill", 32'(bus.fill_o), 32'd4);
      chk("ovf_flag", 32'(bus.ovf_o), 32'd1);
      drain();

      pulse_clr();
      for (int i = 0; i < 4; i++) good_frame(8'(8'h11 + i), 1'b0);
      good_frame(8'h77, 1'b1);
      chk("fullpp_fill", 32'(bus.fill_o), 32'd4);
      chk("fullpp_ovf", 32'(bus.ovf_o), 32'd0);
      drain();

      // Reset while held in CT_CLR_WAIT by a flag that is still high.
      bus.rcvr_rdy_i  = 1'b1;
      bus.rcvr_data_i = 8'h5A;
      tick();
      ann_push = 1'b1;
      ann_data = 8'h5A;
      exp_rdy_pulses++;
      tick();
      bus.rcvr_rdy_i  = 1'b1;
      bus.rcvr_data_i = 8'hC3;
      tick();
      rst_i = 1'b1;
      #1;
      chk("arst_fill", 32'(bus.fill_o), 32'd0);
      chk("arst_m_valid", 32'(bus.m_valid_o), 32'd0);
      chk("arst_rdy_clr", 32'(bus.rdy_clr_o), 32'd0);
      chk("arst_err_cnt", 32'(bus.err_cnt_o), 32'd0);
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_err = 0;
      tick();
      rst_i = 1'b0;
      tick();
      ann_push = 1'b1;
      ann_data = 8'hC3;
      exp_rdy_pulses++;
      wait_idle(2);
      chk("arst_service_fill", 32'(bus.fill_o), 32'd1);
      drain();

      pulse_clr();
      for (int i = 0; i < 260; i++) err_frame(0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("sat_cnt", 32'(bus.err_cnt_o), 32'd255);
      err_frame(0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("sat_clr_cnt", 32'(bus.err_cnt_o), 32'd0);

      for (int i = 0; i < 200; i++) begin
         bus.m_ready_i = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 15) == 0) pulse_clr();
         case ($urandom_range(0, 3))
            0, 1:    good_frame(8'($urandom), 1'b0);
            2:       err_frame(int'($urandom_range(0, 9)), 1'b1, 1'b0, 1'b0, 8'($urandom));
            default: err_frame(0, 1'b0, ($urandom_range(0, 1) == 1), 1'b0, 8'($urandom));
         endcase
      end
      drain();

      chk("rdy_clr_pulses", 32'(mon_rdy_pulses), 32'(exp_rdy_pulses));
      chk("err_clr_pulses", 32'(mon_err_pulses), 32'(exp_err_pulses));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
